reg_skid: RTL and testbench
===========================

Name: reg_skid

Overview:
- Valid/ready pipeline register stage with a one-entry skid slot. Sits between a producer and the plain reset register stage of the sequential datapath.
- Registers data with 1-cycle latency and sustains 1 transfer/clk under backpressure.
- in_ready is a direct state decode, with no combinational path from out_ready, so chained stages close timing.

Parameters:
- Width, 8, data bus width in bits (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  upstream data valid
- in_ready  output  1  stage can accept (state != FULL)
- in_data  input  Width  upstream data
- out_valid  output  1  out_data valid (state != EMPTY)
- out_ready  input  1  downstream accepts
- out_data  output  Width  registered data (main register)

Behaviour:
- Reset: reset is clk is asynchronous and active-high (rst); clock is clk. While rst=1:
  - state=EMPTY, main=0, skid=0.
  - out_valid=0, out_data=0, in_ready=1.
  - Asserting rst mid-operation discards both entries immediately.
- Handshakes:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- States (2-bit encoding, registered):
  - EMPTY: 0 entries.
  - BUSY: main holds 1 entry.
  - FULL: main and skid both hold entries.
- Transitions:
  - EMPTY, in_valid: main<=in_data -> BUSY. Otherwise stay.
  - BUSY, in_valid & out_ready: main<=in_data, stay BUSY (streaming).
  - BUSY, in_valid & !out_ready: skid<=in_data -> FULL.
  - BUSY, !in_valid & out_ready: -> EMPTY. main retains its value (don't-care).
  - BUSY, !in_valid & !out_ready: hold.
  - FULL, out_ready: main<=skid -> BUSY. in_ready=0, so no input is taken this cycle.
  - FULL, !out_ready: hold.
- Latency: data accepted at edge N appears on out_data with out_valid=1 after edge N (EMPTY case).
- Ordering: strict FIFO; main is always older than skid.
- Stability: while out_valid & !out_ready, out_data and out_valid do not change.
- Data registers load only on the transitions listed above, with no enable elsewhere.
- Inputs while in_ready=0 are ignored; the upstream is required to hold them.
- Illegal state encoding -> EMPTY (default branch).
- Pure data pass-through: no arithmetic, no width conversion.

Decomposition:
- Shared package/header: state encodings ST_EMPTY=2'd0, ST_BUSY=2'd1, ST_FULL=2'd2.
- One sub-module is natural for the two data registers: reg_rst_en, an enabled variant of the team's reset register. It has a Width parameter, async active-high rst to 0, and a load enable. Instantiate it twice (main, skid).
- The FSM stays in reg_skid.

Test Plan:
- Reset mid-stream: state FULL holding 0x11/0x22, pulse rst between edges -> out_valid=0, out_data=0, in_ready=1 immediately, without waiting for a clock edge.
- Single transfer: in_valid=1, in_data=0xA5 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=0xA5; the following cycle out_valid=0.
- Streaming: in_valid=1 with data 0x01..0x10 on consecutive cycles, out_ready=1 -> out_data 0x01..0x10 on consecutive cycles, 1 cycle delayed, in_ready never drops.
- Backpressure/skid: stream 0x30,0x31,0x32 with out_ready=0 from the 2nd cycle, then out_ready=1 after 3 cycles:
  - in_ready=0 once 0x30 and 0x31 are held; 0x32 waits upstream.
  - Outputs 0x30, 0x31, 0x32 in order, none lost or duplicated.
  - out_data stays 0x30 throughout the stall.
- Drain: FULL with 0x40/0x41, in_valid=0, out_ready=1 -> 0x40 then 0x41 on consecutive cycles, then out_valid=0, state EMPTY.
- Randomized valid/ready toggling, 1000 words, scoreboard -> exact in-order match and zero data change while stalled.

Source files
------------

// File: rtl/reg_skid_pkg.sv
// Shared definitions for the reg_skid valid/ready pipeline stage.
//   state_e      : occupancy state of the stage (EMPTY / BUSY / FULL)
//   DefaultWidth : default data bus width in bits
package reg_skid_pkg;

  localparam int unsigned DefaultWidth = 8;

  // Number of entries held: EMPTY=0, BUSY=1 (main), FULL=2 (main + skid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/reg_skid_if.sv
// Handshake bundle for reg_skid: upstream (in_*) and downstream (out_*) valid/ready channels.
//   slave  : view of the stage itself (accepts in_*, drives out_*)
//   master : view of the environment around the stage (drives in_*, accepts out_*)
interface reg_skid_if #(
  parameter int unsigned Width = reg_skid_pkg::DefaultWidth
) ();

  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/reg_rst_en.sv
// Enabled reset register: loads i_d on a rising clk edge when i_en is high.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears the register to 0
//   i_en : load enable
//   i_d  : next data
//   o_q  : registered data
module reg_rst_en
  import reg_skid_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_skid.sv
// Valid/ready pipeline register with a one-entry skid slot.
// Data accepted on an edge appears on out_data after that edge; full throughput is
// sustained under backpressure because a word arriving while the output stalls lands
// in the skid register. in_ready and out_valid decode the state register only, so no
// combinational path runs from out_ready to in_ready.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset (empties the stage, clears both data registers)
//   bus : handshake bundle (slave view): in_valid/in_ready/in_data, out_valid/out_ready/out_data
module reg_skid
  import reg_skid_pkg::*;
#(
  parameter int unsigned Width = DefaultWidth
) (
  input  logic       clk,
  input  logic       rst,
  reg_skid_if.slave  bus
);

  state_e           r_state;
  state_e           w_state_d;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_main_from_skid;
  logic [Width-1:0] w_main_d;
  logic [Width-1:0] w_main_q;
  logic [Width-1:0] w_skid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_main_en        = 1'b0;
    w_skid_en        = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (bus.in_valid) begin
          w_main_en = 1'b1;
          w_state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.in_valid && bus.out_ready) begin
          // Streaming: the old word leaves while the new one replaces it.
          w_main_en = 1'b1;
        end else if (bus.in_valid) begin
          w_skid_en = 1'b1;
          w_state_d = ST_FULL;
        end else if (bus.out_ready) begin
          // main keeps its stale value; out_valid=0 masks it.
          w_state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so no new word competes with the skid refill.
        if (bus.out_ready) begin
          w_main_en        = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_d        = ST_BUSY;
        end
      end
      default: begin
        w_state_d = ST_EMPTY;
      end
    endcase
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : bus.in_data;

  reg_rst_en #(
    .Width (Width)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_main_en),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  reg_rst_en #(
    .Width (Width)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_skid_en),
    .i_d  (bus.in_data),
    .o_q  (w_skid_q)
  );

  assign bus.in_ready  = (r_state != ST_FULL);
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.out_data  = w_main_q;

endmodule

// File: tb/tb_reg_skid.sv
// Self-checking bench for reg_skid. The reference is a 2-deep FIFO held in a queue:
// in_ready = fewer than 2 words held, out_valid = at least 1 word held, out_data = oldest.
module tb_reg_skid;

  localparam int unsigned W = 8;
  localparam int unsigned NumRand = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  reg_skid_if #(.Width(W)) bus ();

  reg_skid #(.Width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [W-1:0] m_q[$];
  logic         m_acc_in  = 1'b0;
  bit           sb_on     = 1'b0;
  int           n_acc     = 0;
  logic [W-1:0] sent[$];
  logic [W-1:0] recv[$];
  logic         stall     = 1'b0;
  logic [W-1:0] stall_data = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_acc_in = 1'b0;
      stall    = 1'b0;
    end else begin
      logic acc_in, acc_out;
      acc_in  = bus.in_valid && (m_q.size() < 2);
      acc_out = bus.out_ready && (m_q.size() > 0);
      // Stall seen by the DUT just before this edge: its outputs must not move.
      stall      = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
      if (sb_on && bus.out_valid && bus.out_ready) recv.push_back(bus.out_data);
      if (sb_on && acc_in) begin
        sent.push_back(bus.in_data);
        n_acc++;
      end
      if (acc_out) void'(m_q.pop_front());
      if (acc_in) m_q.push_back(bus.in_data);
      m_acc_in = acc_in;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (m_q.size() < 2)});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, (m_q.size() > 0)});
      if (m_q.size() > 0) chk("out_data", {24'd0, bus.out_data}, {24'd0, m_q[0]});
      if (stall) begin
        chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_data", {24'd0, bus.out_data}, {24'd0, stall_data});
      end
    end
  end

  // Apply inputs across one rising edge; return 1 time unit after it.
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic [W-1:0] d,
                            input logic ir);
    chk({name, ".valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    if (v) chk({name, ".data"}, {24'd0, bus.out_data}, {24'd0, d});
    chk({name, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, ir});
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single transfer
    cyc(1'b1, 8'hA5, 1'b1);
    expect_out("single", 1'b1, 8'hA5, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    expect_out("single_after", 1'b0, 8'h00, 1'b1);

    // Streaming 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, W'(i), 1'b1);
      expect_out("stream", 1'b1, W'(i), 1'b1);
    end
    cyc(1'b0, 8'h00, 1'b1);
    expect_out("stream_end", 1'b0, 8'h00, 1'b1);

    // Backpressure into the skid slot
    cyc(1'b1, 8'h30, 1'b1);
    expect_out("bp0", 1'b1, 8'h30, 1'b1);
    cyc(1'b1, 8'h31, 1'b0);
    expect_out("bp_full", 1'b1, 8'h30, 1'b0);
    cyc(1'b1, 8'h32, 1'b0);
    expect_out("bp_stall1", 1'b1, 8'h30, 1'b0);
    cyc(1'b1, 8'h32, 1'b0);
    expect_out("bp_stall2", 1'b1, 8'h30, 1'b0);
    cyc(1'b1, 8'h32, 1'b1);
    expect_out("bp_refill", 1'b1, 8'h31, 1'b1);
    cyc(1'b1, 8'h32, 1'b1);
    expect_out("bp_last", 1'b1, 8'h32, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    expect_out("bp_empty", 1'b0, 8'h00, 1'b1);

    // Drain from FULL
    cyc(1'b1, 8'h40, 1'b0);
    cyc(1'b1, 8'h41, 1'b0);
    expect_out("drain_full", 1'b1, 8'h40, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    expect_out("drain1", 1'b1, 8'h41, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    expect_out("drain_empty", 1'b0, 8'h00, 1'b1);

    // Reset mid-stream while FULL: outputs must clear without a clock edge
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    expect_out("mid_full", 1'b1, 8'h11, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst.out_data", {24'd0, bus.out_data}, 32'd0);
    chk("midrst.in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b1);
    expect_out("midrst_after", 1'b0, 8'h00, 1'b1);

    // Random valid/ready traffic; upstream holds its word until accepted
    sb_on = 1'b1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20 * NumRand && n_acc < NumRand; k++) begin
      if (!(bus.in_valid && !m_acc_in)) begin
        bus.in_valid = (n_acc < NumRand) && ($urandom_range(3) != 0);
        bus.in_data  = W'($urandom);
      end
      bus.out_ready = ($urandom_range(2) != 0);
      @(posedge clk);
      #1;
    end
    chk("rand.accepted", n_acc, NumRand);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && m_q.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("rand.drained", m_q.size(), 0);
    sb_on = 1'b0;
    chk("rand.count", recv.size(), sent.size());
    for (int i = 0; i < sent.size() && i < recv.size(); i++) begin
      chk("rand.order", {24'd0, recv[i]}, {24'd0, sent[i]});
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
